// File: rtl/lb_depth_feeder_pkg.sv
// Shared configuration for the RGB-D front end: datapath widths, line-buffer depth,
// and the feeder state encoding used by lb_depth_feeder.
package RgbdVoConfigPk;

  localparam int H_SIZE_BW     = 12;
  localparam int V_SIZE_BW     = 12;
  localparam int DATA_DEPTH_BW = 16;
  localparam int DATA_RGB_BW   = 24;
  localparam int LB_ROWS       = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/lb_depth_feeder_credit.sv
// Line-buffer row credit counter: starts full, -1 per admitted row, +1 per released row.
// A release that would exceed the buffer depth is dropped and latches a sticky error.
module lb_row_credit #(
  parameter int LB_ROWS   = 64,
  parameter int CREDIT_BW = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_take,
  input  logic                 i_release,
  input  logic                 i_err_clr,
  output logic [CREDIT_BW-1:0] o_credits,
  output logic                 o_err
);

  localparam logic [CREDIT_BW-1:0] FULL = CREDIT_BW'(LB_ROWS);

  logic full;
  logic overflow;

  assign full     = (o_credits == FULL);
  // A take in the same cycle cancels the release, so it can never overflow.
  assign overflow = i_release && !i_take && full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_credits <= FULL;
      o_err     <= 1'b0;
    end else begin
      if (i_take && !i_release) begin
        o_credits <= o_credits - CREDIT_BW'(1);
      end else if (i_release && !i_take && !full) begin
        o_credits <= o_credits + CREDIT_BW'(1);
      end
      // An overflow in the frame-start cycle still gets recorded.
      if (overflow) begin
        o_err <= 1'b1;
      end else if (i_err_clr) begin
        o_err <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lb_depth_feeder.sv
// Raster feeder into the line-buffer writer port, gated per row by line-buffer credits.
// Optional build macro LB_FEEDER_STALL_CNT_EN adds a saturating credit-stall cycle counter.
module lb_depth_feeder
  import RgbdVoConfigPk::*;
#(
  parameter int LB_ROWS   = RgbdVoConfigPk::LB_ROWS,
  parameter int CREDIT_BW = 7
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [H_SIZE_BW-1:0]     r_hsize,
  input  logic [V_SIZE_BW-1:0]     r_vsize,
  input  logic                     i_src_valid,
  input  logic [DATA_DEPTH_BW-1:0] i_src_depth,
  input  logic [DATA_RGB_BW-1:0]   i_src_data,
  output logic                     o_src_ready,
  input  logic                     i_row_release,
  output logic                     o_frame_start,
  output logic                     o_frame_end,
  output logic                     o_valid1,
  output logic [DATA_DEPTH_BW-1:0] o_depth1,
  output logic [DATA_RGB_BW-1:0]   o_data1,
  output logic [H_SIZE_BW-1:0]     o_idx1_x,
  output logic [V_SIZE_BW-1:0]     o_idx1_y,
  output logic                     o_busy,
`ifdef LB_FEEDER_STALL_CNT_EN
  output logic [15:0]              o_stall_cycles,
`endif
  output logic                     o_credit_err
);

  feeder_state_t        state, state_nxt;
  logic [H_SIZE_BW-1:0] x_cnt;
  logic [V_SIZE_BW-1:0] y_cnt;
  logic [CREDIT_BW-1:0] credits;
  logic                 start_frame;
  logic                 accept;
  logic                 row_take;
  logic                 last_x;
  logic                 last_y;

  assign start_frame = (state == IDLE) && i_start;
  // Admission is only gated at the row start; a started row always completes.
  assign o_src_ready = (state == RUN) && ((x_cnt != '0) || (credits != '0));
  assign accept      = i_src_valid && o_src_ready;
  assign row_take    = accept && (x_cnt == '0);
  assign last_x      = (x_cnt == r_hsize - H_SIZE_BW'(1));
  assign last_y      = (y_cnt == r_vsize - V_SIZE_BW'(1));
  assign o_busy      = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (accept && last_x && last_y) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (start_frame) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (last_x) begin
        x_cnt <= '0;
        y_cnt <= last_y ? '0 : y_cnt + V_SIZE_BW'(1);
      end else begin
        x_cnt <= x_cnt + H_SIZE_BW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid1      <= 1'b0;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_depth1      <= '0;
      o_data1       <= '0;
      o_idx1_x      <= '0;
      o_idx1_y      <= '0;
    end else begin
      o_valid1      <= accept;
      o_frame_start <= accept && (x_cnt == '0) && (y_cnt == '0);
      o_frame_end   <= accept && last_x && last_y;
      if (accept) begin
        o_depth1 <= i_src_depth;
        o_data1  <= i_src_data;
        o_idx1_x <= x_cnt;
        o_idx1_y <= y_cnt;
      end
    end
  end

  lb_row_credit #(
    .LB_ROWS   (LB_ROWS),
    .CREDIT_BW (CREDIT_BW)
  ) u_credit (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_take    (row_take),
    .i_release (i_row_release),
    .i_err_clr (start_frame),
    .o_credits (credits),
    .o_err     (o_credit_err)
  );

`ifdef LB_FEEDER_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
    end else if (start_frame) begin
      o_stall_cycles <= '0;
    end else if ((state == RUN) && i_src_valid && !o_src_ready && (o_stall_cycles != 16'hFFFF)) begin
      o_stall_cycles <= o_stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lb_depth_feeder.sv
// Randomized + directed bench for lb_depth_feeder with a frame-level reference model
// and a scoreboard queue drained by an independent output monitor.
module tb_lb_depth_feeder;
  import RgbdVoConfigPk::*;

  localparam int LBR = 3;

  typedef struct {
    logic [DATA_DEPTH_BW-1:0] d;
    logic [DATA_RGB_BW-1:0]   r;
    logic [H_SIZE_BW-1:0]     x;
    logic [V_SIZE_BW-1:0]     y;
    bit                       fs;
    bit                       fe;
    int                       due;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start;
  logic [H_SIZE_BW-1:0]     hsize;
  logic [V_SIZE_BW-1:0]     vsize;
  logic                     src_valid;
  logic [DATA_DEPTH_BW-1:0] src_depth;
  logic [DATA_RGB_BW-1:0]   src_data;
  logic                     src_ready;
  logic                     row_release;
  logic                     frame_start, frame_end, valid1, busy, credit_err;
  logic [DATA_DEPTH_BW-1:0] depth1;
  logic [DATA_RGB_BW-1:0]   data1;
  logic [H_SIZE_BW-1:0]     idx_x;
  logic [V_SIZE_BW-1:0]     idx_y;
`ifdef LB_FEEDER_STALL_CNT_EN
  logic [15:0]              stall_cycles;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fs_cyc, fe_cyc;

  // Reference model state: phase 0=idle 1=running 2=finishing, pixel index within frame.
  int m_phase, m_n, m_cred, m_stall, h, v;
  bit m_err;
  exp_t exp_q[$];
  exp_t me;
  logic [DATA_DEPTH_BW-1:0] last_d;
  logic [DATA_RGB_BW-1:0]   last_r;
  logic [H_SIZE_BW-1:0]     last_x;
  logic [V_SIZE_BW-1:0]     last_y;

  lb_depth_feeder #(.LB_ROWS(LBR), .CREDIT_BW(7)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .r_hsize       (hsize),
    .r_vsize       (vsize),
    .i_src_valid   (src_valid),
    .i_src_depth   (src_depth),
    .i_src_data    (src_data),
    .o_src_ready   (src_ready),
    .i_row_release (row_release),
    .o_frame_start (frame_start),
    .o_frame_end   (frame_end),
    .o_valid1      (valid1),
    .o_depth1      (depth1),
    .o_data1       (data1),
    .o_idx1_x      (idx_x),
    .o_idx1_y      (idx_y),
    .o_busy        (busy),
`ifdef LB_FEEDER_STALL_CNT_EN
    .o_stall_cycles(stall_cycles),
`endif
    .o_credit_err  (credit_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string nm, input longint act, input longint expv);
    total = total + 1;
    if (act !== expv) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_cred = LBR; m_stall = 0; m_err = 1'b0;
    exp_q.delete();
    last_d = '0; last_r = '0; last_x = '0; last_y = '0;
  endtask

  task automatic set_size(input int a, input int b);
    h = a; v = b;
    hsize = H_SIZE_BW'(a);
    vsize = V_SIZE_BW'(b);
  endtask

  // One clock of stimulus: drive, check model-visible status, advance model across the edge.
  task automatic step(input bit vld, input bit rel, input bit st, output bit acc, output int xo);
    bit rdy, take, ovf, start_now;
    exp_t e;
    src_valid = vld; row_release = rel; start = st;
    src_depth = DATA_DEPTH_BW'($urandom);
    src_data  = DATA_RGB_BW'($urandom);
    @(negedge clk);
    rdy = (m_phase == 1) && ((m_n % h) != 0 || m_cred != 0);
    check("src_ready", longint'(src_ready), longint'(rdy));
    check("busy", longint'(busy), longint'(m_phase == 1));
    check("credit_err", longint'(credit_err), longint'(m_err));
`ifdef LB_FEEDER_STALL_CNT_EN
    check("stall_cycles", longint'(stall_cycles), longint'(m_stall));
`endif
    start_now = (m_phase == 0) && st;
    acc  = vld && rdy;
    xo   = m_n % h;
    take = acc && (xo == 0);
    if (m_phase == 1 && vld && !rdy && m_stall < 65535) m_stall++;
    if (start_now) m_stall = 0;
    ovf = rel && !take && (m_cred == LBR);
    if (take && !rel) m_cred--;
    else if (rel && !take && !ovf) m_cred++;
    if (ovf) m_err = 1'b1;
    else if (start_now) m_err = 1'b0;
    if (acc) begin
      e.d = src_depth; e.r = src_data;
      e.x = H_SIZE_BW'(xo); e.y = V_SIZE_BW'(m_n / h);
      e.fs = (m_n == 0); e.fe = (m_n == h * v - 1);
      e.due = cyc + 1;
      exp_q.push_back(e);
      m_n++;
    end
    case (m_phase)
      0: if (st) begin m_phase = 1; m_n = 0; end
      1: if (acc && m_n == h * v) m_phase = 2;
      default: m_phase = 0;
    endcase
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid1) begin
        if (exp_q.size() == 0) begin
          total = total + 1; bad = bad + 1;
          $display("FAIL unexpected_valid: got x=%0d y=%0d expected no pixel", idx_x, idx_y);
        end else begin
          me = exp_q.pop_front();
          check("latency", longint'(cyc), longint'(me.due));
          check("depth1", longint'(depth1), longint'(me.d));
          check("data1", longint'(data1), longint'(me.r));
          check("idx_x", longint'(idx_x), longint'(me.x));
          check("idx_y", longint'(idx_y), longint'(me.y));
          check("frame_start", longint'(frame_start), longint'(me.fs));
          check("frame_end", longint'(frame_end), longint'(me.fe));
          last_d = me.d; last_r = me.r; last_x = me.x; last_y = me.y;
        end
        if (frame_start) fs_cyc = cyc;
        if (frame_end) fe_cyc = cyc;
      end else begin
        if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
          total = total + 1; bad = bad + 1;
          $display("FAIL missing_pixel: got no valid expected x=%0d y=%0d", exp_q[0].x, exp_q[0].y);
          void'(exp_q.pop_front());
        end
        check("idle_pulses", longint'({frame_start, frame_end}), 0);
        check("hold_data", longint'({depth1, data1}), longint'({last_d, last_r}));
        check("hold_idx", longint'({idx_x, idx_y}), longint'({last_x, last_y}));
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, "_ctl"}, longint'({valid1, frame_start, frame_end, busy, credit_err, src_ready}), 0);
    check({nm, "_dat"}, longint'({depth1, data1}), 0);
    check({nm, "_idx"}, longint'({idx_x, idx_y}), 0);
    check({nm, "_cred"}, longint'(dut.u_credit.o_credits), longint'(LBR));
  endtask

  initial begin
    bit acc, pend;
    int xo, guard;
    rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; row_release = 1'b0;
    src_depth = '0; src_data = '0;
    set_size(4, 3);
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full 4x3 frame, source always valid, row released one cycle after its last pixel.
    fs_cyc = -1; fe_cyc = -100; pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pend, i == 0, acc, xo);
      pend = acc && (xo == 3);
    end
    check("frame_span", longint'(fe_cyc - fs_cyc), 11);
    check("credits_back", longint'(dut.u_credit.o_credits), longint'(LBR));

    // Run out of credits on a 4x4 frame, stall, then resume with a single release.
    set_size(4, 4);
    step(1'b0, 1'b0, 1'b1, acc, xo);
    guard = 0;
    while (m_n != 4 * LBR && guard < 40) begin
      step(1'b1, 1'b0, 1'b0, acc, xo);
      guard++;
    end
    if (guard >= 40) begin
      total++; bad++;
      $display("FAIL stall_timeout: got %0d pixels expected %0d", m_n, 4 * LBR);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, acc, xo);
    step(1'b0, 1'b1, 1'b0, acc, xo);
    step(1'b1, 1'b1, 1'b0, acc, xo);
    check("cred_take_rel", longint'(dut.u_credit.o_credits), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, acc, xo);
    for (int i = 0; i < LBR; i++) step(1'b0, 1'b1, 1'b0, acc, xo);
    step(1'b0, 1'b0, 1'b0, acc, xo);
    check("cred_err_set", longint'(credit_err), 1);
    check("cred_full", longint'(dut.u_credit.o_credits), longint'(LBR));

    // 1x1 frame: start and end pulses coincide; start also clears error and stall count.
    set_size(1, 1);
    step(1'b0, 1'b0, 1'b1, acc, xo);
    step(1'b1, 1'b0, 1'b0, acc, xo);
    step(1'b0, 1'b1, 1'b0, acc, xo);
    step(1'b0, 1'b0, 1'b0, acc, xo);

    // Random traffic; sizes only change while idle.
    for (int i = 0; i < 1500; i++) begin
      if (m_phase == 0 && $urandom_range(0, 3) == 0)
        set_size(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2, $urandom_range(0, 7) == 0, acc, xo);
    end
    guard = 0;
    while (m_phase != 0 && guard < 200) begin
      step(1'b1, 1'b1, 1'b0, acc, xo);
      guard++;
    end
    guard = 0;
    while (m_cred < LBR && guard < 10) begin
      step(1'b0, 1'b1, 1'b0, acc, xo);
      guard++;
    end

    // Asynchronous reset in the middle of a frame, just before pixel (2,1).
    set_size(4, 3);
    step(1'b0, 1'b0, 1'b1, acc, xo);
    guard = 0;
    while (m_n != 6 && guard < 30) begin
      step(1'b1, 1'b0, 1'b0, acc, xo);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    src_valid = 1'b0; start = 1'b0; row_release = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("midreset_edge");
    rst_n = 1'b1;
    fs_cyc = -1; pend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pend, i == 0, acc, xo);
      pend = acc && (xo == 3);
    end
    check("restart_fs_seen", longint'(fs_cyc > 0), 1);
    check("restart_cred", longint'(dut.u_credit.o_credits), longint'(LBR));

    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, acc, xo);
    check("queue_drain", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
